// File: rtl/stream_to_simple_write_pkg.sv
// Shared types and helpers for the stream-to-simple-write feeder.
package stream_to_simple_write_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BURST = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Largest word-aligned byte count that still fits in a len_w-bit length field.
  function automatic int max_chunk_bytes(input int len_w);
    return ((1 << len_w) - 1) & ~3;
  endfunction

  function automatic logic [3:0] strb_from_residue(input logic [1:0] residue);
    case (residue)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/stream_to_simple_write_fifo.sv
// Synchronous FIFO with registered storage; the head word is read straight from the array.
module simple_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stream_to_simple_write.sv
// Buffers a job's data stream and issues it as fully-buffered chunks on the simple write interface.
//   state | meaning
//   IDLE  | no job; waiting for cfg_start_i
//   FILL  | waiting until the next chunk is completely in the FIFO
//   BURST | chunk presented to the bridge, one word popped per accepted beat
//   GAP   | one idle cycle between chunks; ends the job when nothing remains
module stream_to_simple_write
  import stream_to_simple_write_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cfg_start_i,
  input  logic [AXI_ADDR_W-1:0]   cfg_addr_i,
  input  logic [31:0]             cfg_bytes_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [AXI_DATA_W-1:0]   s_data_i,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  output logic [AXI_ADDR_W-1:0]   m_waddr_o,
  output logic [AXI_DATA_W-1:0]   m_wdata_o,
  output logic [AXI_DATA_W/8-1:0] m_wstrb_o,
  output logic [LEN_W-1:0]        m_wlen_o,
  input  logic                    m_wlast_i
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MAX_CHUNK = 32'(max_chunk_bytes(LEN_W));
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = {{(AXI_ADDR_W-2){1'b1}}, 2'b00};

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] cur_addr;
  logic [31:0]           remaining;
  logic [29:0]           total_words;
  logic [29:0]           words_accepted;
  logic [1:0]            residue;
  logic [LEN_W-1:0]      chunk_words_q;
  logic [LEN_W-1:0]      word_cnt;
  logic [AXI_ADDR_W-1:0] waddr_q;
  logic [LEN_W-1:0]      wlen_q;
  logic                  done_q;
  logic                  error_q;

  logic [31:0]           chunk_bytes;
  logic [LEN_W-1:0]      chunk_words;
  logic                  start_ok;
  logic                  chunk_ready;
  logic                  pop_evt;
  logic                  cnt_last;
  logic                  err_evt;
  logic                  is_final;

  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [AXI_DATA_W-1:0] fifo_head;

  assign chunk_bytes = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
  assign chunk_words = LEN_W'((chunk_bytes + 32'd3) >> 2);
  assign start_ok    = (state_q == S_IDLE) & cfg_start_i;
  assign chunk_ready = 32'(fifo_count) >= 32'(chunk_words);
  assign pop_evt     = (state_q == S_BURST) & m_wready_i & ~fifo_empty;
  assign cnt_last    = (word_cnt == chunk_words_q - LEN_W'(1));
  // Bridge's last flag must coincide exactly with our own word count.
  assign err_evt     = pop_evt & (m_wlast_i != cnt_last);
  assign is_final    = cnt_last & (remaining == 32'(wlen_q));
  assign fifo_push   = s_valid_i & s_ready_o;

  simple_sync_fifo #(
    .WIDTH (AXI_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush   (err_evt),
    .push    (fifo_push),
    .wdata   (s_data_i),
    .pop     (pop_evt),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok && cfg_bytes_i != 32'd0) state_d = S_FILL;
      S_FILL:  if (chunk_ready) state_d = S_BURST;
      S_BURST: begin
        if (err_evt)                   state_d = S_IDLE;
        else if (pop_evt && m_wlast_i) state_d = S_GAP;
      end
      S_GAP:   state_d = (remaining == 32'd0) ? S_IDLE : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = done_q;
    error_o    = error_q;
    m_wvalid_o = (state_q == S_BURST);
    s_ready_o  = busy_o & ~fifo_full & (words_accepted < total_words);
    m_waddr_o  = waddr_q;
    m_wlen_o   = wlen_q;
    m_wdata_o  = m_wvalid_o ? fifo_head : '0;
    m_wstrb_o  = '0;
    if (m_wvalid_o) m_wstrb_o = is_final ? STRB_W'(strb_from_residue(residue)) : '1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_addr       <= '0;
      remaining      <= '0;
      total_words    <= '0;
      words_accepted <= '0;
      residue        <= '0;
      chunk_words_q  <= '0;
      word_cnt       <= '0;
      waddr_q        <= '0;
      wlen_q         <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_push) words_accepted <= words_accepted + 30'd1;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            cur_addr       <= cfg_addr_i & ADDR_MASK;
            remaining      <= cfg_bytes_i;
            total_words    <= cfg_bytes_i[31:2] + 30'(|cfg_bytes_i[1:0]);
            words_accepted <= '0;
            residue        <= cfg_bytes_i[1:0];
            error_q        <= 1'b0;
            done_q         <= (cfg_bytes_i == 32'd0);
          end
        end
        S_FILL: begin
          if (chunk_ready) begin
            waddr_q       <= cur_addr;
            wlen_q        <= chunk_bytes[LEN_W-1:0];
            chunk_words_q <= chunk_words;
            word_cnt      <= '0;
          end
        end
        S_BURST: begin
          if (err_evt) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
          end else if (pop_evt) begin
            word_cnt <= word_cnt + LEN_W'(1);
            if (m_wlast_i) begin
              cur_addr  <= cur_addr + AXI_ADDR_W'(wlen_q);
              remaining <= remaining - 32'(wlen_q);
            end
          end
        end
        S_GAP: begin
          if (remaining == 32'd0) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stream_to_simple_write.md
Name: stream_to_simple_write

Overview:
- Upstream feeder for the simple-AXI-to-AXI write bridge.
- Accepts a job (base address, total byte count) and a valid/ready stream of data words, and buffers the words in an internal FIFO.
- Splits the job into chunks of at most MAX_CHUNK_BYTES and presents each chunk on the simple write interface: m_wvalid, m_waddr, m_wlen in bytes, m_wdata, with m_wlast returned by the bridge.
- A chunk is launched only once it is fully buffered, so the AXI W channel never sees a bubble mid-burst.

Parameters:
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, word width; fixed at 32 (4-byte words).
- LEN_W, 8, width of m_wlen_o in bytes.
- FIFO_DEPTH, 64, FIFO words; power of 2; must be ≥ MAX_CHUNK_BYTES/4.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- cfg_start_i  in  1  start pulse; ignored while busy_o=1.
- cfg_addr_i  in  AXI_ADDR_W  base byte address; bits[1:0] are ignored (treated as 0).
- cfg_bytes_i  in  32  total job bytes.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- error_o  out  1  sticky; cleared by the next accepted start.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word ready.
- s_data_i  in  AXI_DATA_W  input word.
- m_wvalid_o  out  1  chunk/data valid to bridge.
- m_wready_i  in  1  bridge accepts current data word.
- m_waddr_o  out  AXI_ADDR_W  chunk byte address.
- m_wdata_o  out  AXI_DATA_W  FIFO head word.
- m_wstrb_o  out  AXI_DATA_W/8  byte strobes.
- m_wlen_o  out  LEN_W  chunk length in bytes.
- m_wlast_i  in  1  bridge marks final word of the chunk.

Behaviour:
- Reset (rst_n_i=0, asynchronous) clears everything:
  - All outputs = 0, FIFO flushed, state = IDLE.
  - A reset mid-job abandons the job; the bridge is reset in the same domain.
- Derived values:
  - MAX_CHUNK_BYTES = largest multiple of 4 ≤ 2^LEN_W−1 (252 at default).
  - total_words = ceil(cfg_bytes/4), 30-bit.
  - chunk_bytes = min(remaining, MAX_CHUNK_BYTES).
  - chunk_words = ceil(chunk_bytes/4).
- Input side:
  - s_ready_o = busy_o & !fifo_full & (words_accepted < total_words).
  - Push on s_valid_i & s_ready_o.
  - Words beyond the job are never accepted.
  - Simultaneous push and pop leaves the FIFO count unchanged.
- State machine:
  - IDLE:
    - On cfg_start_i, latch addr and remaining = cfg_bytes, clear error_o, set busy_o.
    - If cfg_bytes = 0: done_o pulses the next cycle, busy_o drops, no bus activity.
    - Otherwise go to FILL.
  - FILL: when fifo_count ≥ chunk_words, register m_waddr_o = cur_addr, m_wlen_o = chunk_bytes, m_wvalid_o = 1, and go to BURST.
  - BURST:
    - m_wvalid_o is held high and m_waddr_o/m_wlen_o are held stable for the whole chunk.
    - m_wdata_o = FIFO head; pop on m_wvalid_o & m_wready_i.
    - The local word counter increments on each pop.
    - On a pop with m_wlast_i=1: m_wvalid_o←0, cur_addr += chunk_bytes, remaining −= chunk_bytes, go to GAP.
  - GAP (exactly 1 cycle, m_wvalid_o=0): if remaining = 0, pulse done_o, clear busy_o, go to IDLE; else go to FILL.
- Strobes:
  - m_wstrb_o = 4'hF for every word except the final word of the job.
  - For the final word, m_wstrb_o follows cfg_bytes mod 4: 1→4'h1, 2→4'h3, 3→4'h7, 0→4'hF.
- Error (protocol check):
  - Either condition sets error_o:
    - m_wlast_i arrives on a pop whose count ≠ chunk_words.
    - chunk_words pops complete without m_wlast_i.
  - Recovery: m_wvalid_o drops, the FIFO is flushed, done_o pulses and the block returns to IDLE.
- Wrap-around: cur_addr increments modulo 2^AXI_ADDR_W; no 4 KB boundary splitting (the bridge owns that).

Decomposition:
- Shared package:
  - MAX_CHUNK_BYTES function of LEN_W.
  - State encoding (IDLE, FILL, BURST, GAP).
  - Strobe-from-residue function.
- One sub-module: simple_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count).
  - Same clk_i/rst_n_i.
  - No bypass; read data is the registered head.

Test Plan:
- start, addr=0x1000, bytes=16, 4 words streamed → one chunk: m_waddr=0x1000, m_wlen=16, 4 pops all strb 0xF, last on the 4th pop, done_o one cycle after GAP.
- bytes=300, base 0x2000 → chunk 1: addr 0x2000, len 252, 63 words; GAP; chunk 2: addr 0x20FC, len 48, 12 words; error_o=0.
- bytes=10 → one chunk, len 10; s_ready_o drops after 3 words accepted; third word strb 0x3.
- bytes=0 → done_o high exactly one cycle after start; m_wvalid_o and s_ready_o never assert.
- Source gives 1 word per 5 cycles, bytes=252 → m_wvalid_o stays low until 63 words are buffered; then 63 pops with m_wready_i held high have no bubble.
- Bridge model asserts m_wlast_i on word 2 of 4 → error_o=1, done_o pulse, FIFO empty; next start clears error_o.
- rst_n_i low during BURST → all outputs 0 asynchronously; after release a 16-byte job completes normally.
